// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-master round-robin arbiter for the io_devices read and write channels, with timeout
module io_bus_arb_ch #(
  parameter int PW       = 4,
  parameter int TO_WIDTH = 8,
  parameter int TIMEOUT  = 200
) (
  input  logic          clk,
  input  logic          reset_i,
  input  logic [1:0]    req_i,
  input  logic [PW-1:0] pay0_i,
  input  logic [PW-1:0] pay1_i,
  input  logic          dev_ack_i,
  output logic          dev_req_o,
  output logic [PW-1:0] dev_pay_o,
  output logic          gnt_o,
  output logic          fin_o,
  output logic [1:0]    ack_o,
  output logic [1:0]    to_o
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t               state_q, state_d;
  logic                 gnt_q, gnt_d, ptr_q, ptr_d, req_q, req_d, to;
  logic [TO_WIDTH-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]        pay_q, pay_d;
  // state, grant, pointer, timeout counter and registered device request/payload
  always_ff @(posedge clk or negedge reset_i)
    if (!reset_i) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      ptr_q   <= 1'b0;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      pay_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      pay_q   <= pay_d;
    end
  // next state: grant in IDLE, wait for ack or timeout in BUSY, acknowledge master and rotate in RESP
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    pay_d   = pay_q;
    fin_o   = 1'b0;
    to      = 1'b0;
    case (state_q)
      IDLE: if (|req_i) begin
        gnt_d   = &req_i ? ptr_q : req_i[1];
        pay_d   = gnt_d ? pay1_i : pay0_i;
        req_d   = 1'b1;
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (dev_ack_i || cnt_q == TO_WIDTH'(TIMEOUT - 1)) begin
          fin_o   = 1'b1;
          to      = !dev_ack_i;
          req_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        ptr_d   = !gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign dev_req_o = req_q;
  assign dev_pay_o = pay_q;
  assign gnt_o     = gnt_q;
  assign ack_o     = {state_q == RESP && gnt_q, state_q == RESP && !gnt_q};
  assign to_o      = {to && gnt_q, to && !gnt_q};
endmodule

module io_bus_arbiter #(
  parameter int D_WIDTH  = 34,
  parameter int PA_WIDTH = 4,
  parameter int TO_WIDTH = 8,
  parameter int TIMEOUT  = 200
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                m0_in_req_i,
  input  logic [PA_WIDTH-1:0] m0_in_addr_i,
  output logic [D_WIDTH-1:0]  m0_in_data_o,
  output logic                m0_in_ack_o,
  input  logic                m1_in_req_i,
  input  logic [PA_WIDTH-1:0] m1_in_addr_i,
  output logic [D_WIDTH-1:0]  m1_in_data_o,
  output logic                m1_in_ack_o,
  input  logic                m0_out_req_i,
  input  logic [PA_WIDTH-1:0] m0_out_addr_i,
  input  logic [D_WIDTH-1:0]  m0_out_data_i,
  output logic                m0_out_ack_o,
  input  logic                m1_out_req_i,
  input  logic [PA_WIDTH-1:0] m1_out_addr_i,
  input  logic [D_WIDTH-1:0]  m1_out_data_i,
  output logic                m1_out_ack_o,
  output logic                dev_read_req_o,
  output logic [PA_WIDTH-1:0] dev_read_addr_o,
  input  logic [D_WIDTH-1:0]  dev_dout_i,
  input  logic                dev_read_ack_i,
  output logic                dev_write_req_o,
  output logic [PA_WIDTH-1:0] dev_write_addr_o,
  output logic [D_WIDTH-1:0]  dev_din_o,
  input  logic                dev_write_ack_i,
  input  logic                err_clr_i,
  output logic [1:0]          err_o
);
  localparam int WP = PA_WIDTH + D_WIDTH;
  logic               rd_gnt, rd_fin, wr_gnt, wr_fin;
  logic [1:0]         rd_ack, rd_to, wr_ack, wr_to;
  logic [WP-1:0]      wr_pay;
  logic [D_WIDTH-1:0] rd0_q, rd0_d, rd1_q, rd1_d, rd_val;
  logic [1:0]         err_q, err_d;

  io_bus_arb_ch #(.PW(PA_WIDTH), .TO_WIDTH(TO_WIDTH), .TIMEOUT(TIMEOUT)) u_rd (
    .clk(clk), .reset_i(reset_i), .req_i({m1_in_req_i, m0_in_req_i}),
    .pay0_i(m0_in_addr_i), .pay1_i(m1_in_addr_i), .dev_ack_i(dev_read_ack_i),
    .dev_req_o(dev_read_req_o), .dev_pay_o(dev_read_addr_o), .gnt_o(rd_gnt),
    .fin_o(rd_fin), .ack_o(rd_ack), .to_o(rd_to)
  );

  io_bus_arb_ch #(.PW(WP), .TO_WIDTH(TO_WIDTH), .TIMEOUT(TIMEOUT)) u_wr (
    .clk(clk), .reset_i(reset_i), .req_i({m1_out_req_i, m0_out_req_i}),
    .pay0_i({m0_out_addr_i, m0_out_data_i}), .pay1_i({m1_out_addr_i, m1_out_data_i}),
    .dev_ack_i(dev_write_ack_i), .dev_req_o(dev_write_req_o), .dev_pay_o(wr_pay),
    .gnt_o(wr_gnt), .fin_o(wr_fin), .ack_o(wr_ack), .to_o(wr_to)
  );

  // read return data is latched per master on completion; a timeout returns zero; sticky errors with set-over-clear
  always_comb begin
    rd_val = |rd_to ? '0 : dev_dout_i;
    rd0_d  = rd_fin && !rd_gnt ? rd_val : rd0_q;
    rd1_d  = rd_fin && rd_gnt ? rd_val : rd1_q;
    err_d  = (err_clr_i ? 2'b00 : err_q) | rd_to | wr_to;
  end

  // master read data and error flag registers
  always_ff @(posedge clk or negedge reset_i)
    if (!reset_i) begin
      rd0_q <= '0;
      rd1_q <= '0;
      err_q <= '0;
    end else begin
      rd0_q <= rd0_d;
      rd1_q <= rd1_d;
      err_q <= err_d;
    end

  assign m0_in_data_o     = rd0_q;
  assign m1_in_data_o     = rd1_q;
  assign m0_in_ack_o      = rd_ack[0];
  assign m1_in_ack_o      = rd_ack[1];
  assign m0_out_ack_o     = wr_ack[0];
  assign m1_out_ack_o     = wr_ack[1];
  assign dev_write_addr_o = wr_pay[WP-1:D_WIDTH];
  assign dev_din_o        = wr_pay[D_WIDTH-1:0];
  assign err_o            = err_q;
  logic unused_wr_fin;
  assign unused_wr_fin = wr_fin;
endmodule
